// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Types and constants shared by the boot loader and its byte packer.
//   state_e   : loader FSM states
//   HDR_BYTES : header length in bytes (16-bit little-endian word count)
//   CSUM_W    : width of the running XOR checksum
package program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;

    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;

endpackage

// File: rtl/program_loader_byte_packer.sv
// program_loader_byte_packer
// Assembles four stream bytes into one little-endian 32-bit word.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   clr_i       : synchronous clear of byte index and partial word
//   push_i      : a byte is accepted this cycle
//   data_i      : accepted byte
//   word_nxt_o  : word value including the byte being pushed now
//   word_done_o : pulse while the fourth byte of a word is pushed
module program_loader_byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        push_i,
    input  logic [7:0]  data_i,
    output logic [31:0] word_nxt_o,
    output logic        word_done_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;

    // New bytes enter at the top; after four pushes the first byte sits in [7:0].
    assign word_nxt_o  = {data_i, word_q[31:8]};
    assign word_done_o = push_i && (idx_q == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (push_i) begin
            word_q <= word_nxt_o;
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader: parses a framed byte image (2-byte word count, payload
// words, XOR checksum), writes payload words to instruction memory and
// releases the core only after the checksum matches.
//   clk_i          : system clock
//   rst_ni         : asynchronous active-low reset
//   start_i        : begin a load (honoured only in IDLE)
//   in_valid_i     : stream byte available
//   in_data_i      : stream byte
//   in_ready_o     : loader accepts a byte this cycle
//   mem_we_o       : one-cycle memory write strobe
//   mem_waddr_o    : memory word address
//   mem_wdata_o    : memory write data
//   words_loaded_o : payload words written so far
//   cpu_run_o      : image verified, core may run (sticky)
//   err_o          : load failed (sticky)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int AW         = 13,
    parameter int BASE_WADDR = 0,
    parameter int MAX_WORDS  = 8000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [15:0]   words_loaded_o,
    output logic          cpu_run_o,
    output logic          err_o
);

    state_e              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [CSUM_W-1:0]   xor_q, xor_d;
    logic                we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                accept;
    logic                pk_clr;
    logic                pk_push;
    logic [31:0]         pk_word_nxt;
    logic                pk_done;
    logic [15:0]         n_hdr;
    logic [15:0]         cnt_inc;

    program_loader_byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (pk_clr),
        .push_i      (pk_push),
        .data_i      (in_data_i),
        .word_nxt_o  (pk_word_nxt),
        .word_done_o (pk_done)
    );

    // Ready is a pure state decode so it never depends on in_valid.
    assign in_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept     = in_valid_i && in_ready_o;

    assign n_hdr   = {in_data_i, n_q[7:0]};
    assign cnt_inc = cnt_q + 16'd1;

    assign mem_we_o       = we_q;
    assign mem_waddr_o    = waddr_q;
    assign mem_wdata_o    = wdata_q;
    assign words_loaded_o = cnt_q;
    assign cpu_run_o      = (state_q == S_DONE);
    assign err_o          = (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pk_clr  = 1'b0;
        pk_push = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_HDR0;
                    n_d     = '0;
                    cnt_d   = '0;
                    xor_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    n_d[7:0] = in_data_i;
                    xor_d    = xor_q ^ in_data_i;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d   = n_hdr;
                    xor_d = xor_q ^ in_data_i;
                    if (n_hdr > 16'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else if (n_hdr == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    pk_push = 1'b1;
                    xor_d   = xor_q ^ in_data_i;
                    if (pk_done) begin
                        // Register address/data now so they are stable for the
                        // whole WRITE cycle and hold afterwards.
                        we_d    = 1'b1;
                        waddr_d = AW'(32'(BASE_WADDR) + 32'(cnt_q));
                        wdata_d = pk_word_nxt;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == n_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (in_data_i == xor_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader.
module tb_program_loader;

    localparam int AW = 13;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [15:0]   words_loaded;
    logic          cpu_run;
    logic          err;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    program_loader #(.AW(AW), .BASE_WADDR(0), .MAX_WORDS(8000)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (in_ready),
        .mem_we_o       (mem_we),
        .mem_waddr_o    (mem_waddr),
        .mem_wdata_o    (mem_wdata),
        .words_loaded_o (words_loaded),
        .cpu_run_o      (cpu_run),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Record every write; ready must be low whenever the write strobe is high.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa_q.push_back(mem_waddr);
            wd_q.push_back(mem_wdata);
            chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwrites"}, wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk({tag, "_addr0"}, {19'd0, wa_q[0]}, 32'd0);
            chk({tag, "_data0"}, wd_q[0], 32'h0010_0513);
            chk({tag, "_addr1"}, {19'd0, wa_q[1]}, 32'd1);
            chk({tag, "_data1"}, wd_q[1], 32'h0020_0593);
        end
    endtask

    logic [7:0] frame [11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 02 00 | 13 05 10 00 | 93 05 20 00 | B2 (XOR of the ten bytes)
        frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                  8'h93, 8'h05, 8'h20, 8'h00, 8'hB2};

        // Reset values, sampled while reset is asserted
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);
        chk("rst_waddr", {19'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        // start while in reset is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_in_reset_ignored", {31'd0, in_ready}, 32'd0);

        // Two-word load with explicit write timing
        do_reset();
        pulse_start();
        chk("hdr0_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) send_byte(frame[i], 0);
        chk("w0_we", {31'd0, mem_we}, 32'd1);
        chk("w0_ready_low", {31'd0, in_ready}, 32'd0);
        chk("w0_addr", {19'd0, mem_waddr}, 32'd0);
        chk("w0_data", mem_wdata, 32'h0010_0513);
        @(negedge clk);
        chk("w0_ready_back", {31'd0, in_ready}, 32'd1);
        chk("w0_we_low", {31'd0, mem_we}, 32'd0);
        chk("w0_words", {16'd0, words_loaded}, 32'd1);
        chk("w0_data_hold", mem_wdata, 32'h0010_0513);
        for (int i = 6; i < 11; i++) send_byte(frame[i], 0);
        chk("load_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("load_err", {31'd0, err}, 32'd0);
        chk("load_words", {16'd0, words_loaded}, 32'd2);
        chk("load_ready_done", {31'd0, in_ready}, 32'd0);
        check_two_writes("load");

        // Bad checksum
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(frame[i], 0);
        send_byte(8'hB3, 0);
        chk("badcs_err", {31'd0, err}, 32'd1);
        chk("badcs_cpu_run", {31'd0, cpu_run}, 32'd0);
        chk("badcs_words", {16'd0, words_loaded}, 32'd2);
        check_two_writes("badcs");

        // Oversize header: N = 8001 = 0x1F41
        do_reset();
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h1F, 0);
        chk("over_err", {31'd0, err}, 32'd1);
        chk("over_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("over_ready_later", {31'd0, in_ready}, 32'd0);
        chk("over_no_writes", wa_q.size(), 32'd0);
        chk("over_cpu_run", {31'd0, cpu_run}, 32'd0);

        // Empty image
        do_reset();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("empty_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("empty_err", {31'd0, err}, 32'd0);
        chk("empty_words", {16'd0, words_loaded}, 32'd0);
        chk("empty_no_writes", wa_q.size(), 32'd0);

        do_reset();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk("empty_bad_err", {31'd0, err}, 32'd1);
        chk("empty_bad_cpu_run", {31'd0, cpu_run}, 32'd0);

        // Stalled stream; byte 6 is offered during the WRITE cycle
        do_reset();
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(frame[i], (i == 6) ? 0 : int'($urandom_range(0, 7)));
        chk("stall_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("stall_err", {31'd0, err}, 32'd0);
        chk("stall_words", {16'd0, words_loaded}, 32'd2);
        check_two_writes("stall");

        // Reset after five payload bytes, then restart
        do_reset();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
        chk("mid_words_before", {16'd0, words_loaded}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_words", {16'd0, words_loaded}, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_waddr", {19'd0, mem_waddr}, 32'd0);
        chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_run_err", {30'd0, cpu_run, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
        chk("restart_cpu_run", {31'd0, cpu_run}, 32'd1);
        chk("restart_words", {16'd0, words_loaded}, 32'd2);
        check_two_writes("restart");
        pulse_start();
        @(negedge clk);
        chk("done_start_run", {31'd0, cpu_run}, 32'd1);
        chk("done_start_words", {16'd0, words_loaded}, 32'd2);
        chk("done_start_ready", {31'd0, in_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader sitting upstream of the multi-cycle RISC-V core and its unified instruction/data memory. It accepts a byte stream over a valid/ready handshake and parses a small framed image: header, payload words and checksum. It assembles little-endian 32-bit words, writes them into the instruction region of memory, and releases the core (`cpu_run`) only after a checksum-verified load. While `cpu_run` is low, the core is held in reset and memory write ports are muxed to this block.

## Interface
- `AW`, default 13: word-address width of the memory write port.
- `BASE_WADDR`, default 0: word address of the first payload word.
- `MAX_WORDS`, default 8000: largest accepted payload, in words; it equals the instruction-region size.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `in_valid`  in  1  byte available on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `in_valid & in_ready`.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_waddr`  out  AW  word address of the write.
- `mem_wdata`  out  32  assembled word.
- `words_loaded`  out  16  count of payload words written.
- `cpu_run`  out  1  image valid; the core may leave reset. Sticky.
- `err`  out  1  load failed. Sticky.

## Operation
- Frame format:
  - 2 header bytes: N = word count, 16-bit little-endian (byte0 = N[7:0]).
  - 4·N payload bytes: each word is little-endian, first byte = bits [7:0].
  - 1 checksum byte: the XOR of every preceding frame byte, header included.
- States:
  - **IDLE**: `in_ready`=0. On `start` → HDR0.
  - **HDR0**: accept byte → latch N[7:0] → HDR1.
  - **HDR1**: accept byte → latch N[15:8].
    - If N > MAX_WORDS → ERR.
    - Else if N = 0 → CSUM.
    - Else → DATA.
  - **DATA**: accept bytes into a shift register with a 2-bit byte index. On the 4th byte → WRITE.
  - **WRITE**: for one cycle:
    - Drive `mem_we`=1, `mem_waddr` = BASE_WADDR + words_loaded (truncated to AW bits), and `mem_wdata` = the assembled word.
    - Increment `words_loaded` at the end of the cycle.
    - If the incremented count = N → CSUM, else → DATA.
    - `in_ready`=0 during WRITE.
  - **CSUM**: accept byte.
    - If it equals the running XOR → DONE.
    - Else → ERR.
  - **DONE**: `cpu_run`=1 and `in_ready`=0. Terminal until reset. `start` is ignored.
  - **ERR**: `err`=1 and `in_ready`=0. Terminal until reset. `start` is ignored.
- The running XOR clears on leaving IDLE. It updates on every accepted byte except the checksum byte itself.
- `in_ready` is 1 exactly in HDR0, HDR1, DATA and CSUM. The stream may stall with `in_valid`=0 for any number of cycles; state and partial word are held.
- `mem_waddr` and `mem_wdata` hold their last value when `mem_we`=0.
- `words_loaded` clears on `start`.

## Timing
- Reset (asynchronous, `rst`=0) forces:
  - state IDLE;
  - `in_ready`, `mem_we`, `cpu_run`, `err` = 0;
  - `mem_waddr`, `mem_wdata`, `words_loaded`, N, XOR and byte index = 0.
- Reset mid-load aborts immediately. Memory already written is not restored.
- Timing of a write:
  - The 4th byte of a word is accepted in cycle t.
  - `mem_we` is high in cycle t+1.
  - `in_ready` returns high in cycle t+2.
- Peak throughput is 4 bytes per 5 cycles.
- `cpu_run` or `err` rises in the cycle after the checksum byte is accepted. Both are registered outputs.
- Ready does not depend combinationally on `in_valid`.
- `start` asserted in the same cycle as `rst`=0 has no effect.

## Structure
- A shared loader package holds:
  - the state enum (IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR);
  - the header length constant (2 bytes);
  - the checksum width (8).
- The natural sub-module is `byte_packer`: a 4-byte little-endian shift register with a byte index and a `word_done` pulse. The FSM, counters and checksum stay in the top level.

## Test plan
- **Two-word load**: `start`, then bytes 02 00 | 13 05 10 00 | 93 05 20 00 | checksum = XOR of the 10 bytes.
  - Expected writes: addr 0 ← 0x00100513, then addr 1 ← 0x00200593.
  - Expected result: `words_loaded`=2, `cpu_run`=1, `err`=0.
- **Bad checksum**: same frame with the checksum byte XOR 0x01.
  - Expected: both writes occur, then `err`=1 and `cpu_run`=0.
- **Oversize header**: N = MAX_WORDS+1.
  - Expected: `err`=1 after the second header byte, no `mem_we` ever, `in_ready`=0 thereafter.
- **Empty image**: 00 00 00.
  - Expected: `cpu_run`=1, `words_loaded`=0, no writes.
  - Variant 00 00 01: `err`=1.
- **Stalls**: random `in_valid` gaps of 0–7 cycles during the two-word load.
  - Expected: identical writes and result.
  - Check that `in_ready`=0 in every WRITE cycle.
  - Check that the byte offered during WRITE is taken afterwards, not lost.
- **Reset and restart**: `rst` pulsed low after 5 payload bytes.
  - Expected: all outputs return to 0 asynchronously.
  - A fresh `start` plus full frame then loads correctly from address BASE_WADDR.
  - A `start` in DONE is ignored.
